// File: rtl/uart_tx_parity_framer.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB-first, optional parity
// (even/odd/mark/space) accumulated serially, then STOP_BITS stop bits.
module uart_tx_parity_framer #(
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            parity_mode_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  parity_o,
  output logic                  done_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         baud_q;
  logic [CW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [2:0]            mode_q;
  logic                  acc_q, parity_q, done_q;
  logic                  bit_end, accept, parity_en, last_data, last_stop;
  logic                  acc_nx, par_bit;

  assign bit_end   = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign accept    = valid_i && (state_q == S_IDLE);
  assign parity_en = (mode_q >= 3'd1) && (mode_q <= 3'd4);
  assign last_data = (bit_q == CW'(DATA_WIDTH - 1));
  assign last_stop = (bit_q == CW'(STOP_BITS - 1));

  // Parity must include the bit leaving the shifter on this boundary.
  always_comb begin
    acc_nx  = acc_q ^ shreg_q[0];
    par_bit = 1'b0;
    case (mode_q)
      3'd1:    par_bit = acc_nx;
      3'd2:    par_bit = ~acc_nx;
      3'd3:    par_bit = 1'b1;
      default: par_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tx_o    = 1'b1;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_START;
      S_START: begin
        tx_o = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx_o = shreg_q[0];
        if (bit_end && last_data) state_d = parity_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx_o = parity_q;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP:   if (bit_end && last_stop) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign ready_o  = (state_q == S_IDLE);
  assign busy_o   = ~ready_o;
  assign parity_o = parity_q;
  assign done_o   = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      mode_q   <= '0;
      acc_q    <= 1'b0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_STOP) && (state_d == S_IDLE);
      if (state_q == S_IDLE) baud_q <= '0;
      else                   baud_q <= bit_end ? '0 : baud_q + BW'(1);
      case (state_q)
        S_IDLE: if (accept) begin
          shreg_q <= data_i;
          mode_q  <= parity_mode_i;
          acc_q   <= 1'b0;
          bit_q   <= '0;
        end
        S_DATA: if (bit_end) begin
          acc_q   <= acc_nx;
          shreg_q <= shreg_q >> 1;
          bit_q   <= last_data ? '0 : bit_q + CW'(1);
          if (last_data && parity_en) parity_q <= par_bit;
        end
        S_STOP: if (bit_end) bit_q <= bit_q + CW'(1);
        default: ;
      endcase
    end
  end

endmodule
